mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the fetch stage (read-only) and the memory stage (load/store).
- Registers the selected request onto the memory port and waits for the memory's variable-latency ready.
- Returns read data to the winning requester and produces the stall signals the pipeline uses while a requester waits.
- Handles fetch cancellation on branch/jump redirect from execute.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_port_arbiter_chk.sv | 15 +
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
package mem_pkg;

    localparam int ADDR_W_DEF        = 32;
    localparam int DATA_W_DEF        = 32;
    localparam int MAX_DM_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks for the memory port arbiter's requester interfaces.
module mem_port_arbiter_chk
    import mem_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input arb_state_e state_q,
    input logic       dm_req_i
);

    // A data request may not be withdrawn while its transaction is in flight.
    dm_hold_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY_DM) |-> dm_req_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store
// stage, with bounded data priority and fetch cancellation on redirect.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_valid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_valid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ready_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                stall_fetch_o,
    output logic                stall_mem_o
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_DM_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1'b1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
    localparam logic [ADDR_W-1:0]   WORD_MASK   = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e          state_q,     state_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                drop_q,      drop_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [BE_W-1:0]     mem_be_q,    mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_valid_q,  if_valid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic                dm_valid_q,  dm_valid_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                fetch_ok;
    logic                fetch_forced;

    // Arbitration, memory-port sequencing and completion routing.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        drop_d       = drop_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_valid_d   = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        fetch_ok     = if_req_i & ~if_flush_i;
        fetch_forced = fetch_ok & (streak_q == STREAK_MAX);

        case (state_q)
            IDLE: begin
                if (dm_req_i && !fetch_forced) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_be_d    = dm_be_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    // Only data grants that make a waiting fetch wait longer count.
                    if (!if_req_i) begin
                        streak_d = STREAK_ZERO;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_ONE;
                    end else begin
                        streak_d = streak_q;
                    end
                end else if (fetch_ok) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = {BE_W{1'b1}};
                    mem_addr_d  = if_addr_i & WORD_MASK;
                    mem_wdata_d = {DATA_W{1'b0}};
                    streak_d    = STREAK_ZERO;
                    drop_d      = 1'b0;
                end else if (!if_req_i) begin
                    streak_d = STREAK_ZERO;
                end else begin
                    streak_d = streak_q;
                end
            end

            BUSY_IF: begin
                if (mem_ready_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    drop_d    = 1'b0;
                    // A redirect in the completion cycle cancels the fetch as well.
                    if (!(drop_q || if_flush_i)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        if_valid_d = 1'b0;
                    end
                end else if (if_flush_i) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end

            BUSY_DM: begin
                if (mem_ready_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = mem_we_q ? {DATA_W{1'b0}} : mem_rdata_i;
                end else begin
                    dm_valid_d = 1'b0;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= STREAK_ZERO;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= {BE_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_valid_q  <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_valid_q  <= dm_valid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_be_o      = mem_be_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign if_valid_o    = if_valid_q;
    assign if_rdata_o    = if_rdata_q;
    assign dm_valid_o    = dm_valid_q;
    assign dm_rdata_o    = dm_rdata_q;
    assign stall_fetch_o = if_req_i & ~if_valid_q;
    assign stall_mem_o   = dm_req_i & ~dm_valid_q;

    mem_port_arbiter_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .state_q  (state_q),
        .dm_req_i (dm_req_i)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a variable-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, if_flush_i, if_valid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_valid_o;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        stall_fetch_o, stall_mem_o;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        prev_req = 1'b0;
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    bit          grant_log[$];
    int          if_burst = 0, dm_burst = 0;
    int          if_seen = 0, dm_seen = 0, last_if_cyc = 0;
    int          mem_delay = 0, mem_cnt = 0;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .stall_fetch_o(stall_fetch_o), .stall_mem_o(stall_mem_o)
    );

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4)       return 32'h0050_0093;
        else if (idx < 128) return 32'hC0DE_0000 | 32'(idx);
        else                return 32'h0000_0000;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Behavioural memory: ready after mem_delay waiting cycles, contents reloaded on reset.
    assign mem_ready_i = mem_req_o && (mem_cnt >= mem_delay);
    assign mem_rdata_i = mem_ready_i ? mem[mem_addr_o[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            mem_cnt <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_req_o && !mem_ready_i) mem_cnt <= mem_cnt + 1;
            else                           mem_cnt <= 0;
            if (mem_ready_i && mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_grants();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < grant_log.size() && i < 32; i++) v[i] = grant_log[i];
        return v;
    endfunction

    // One clock: log grants, score completions, re-issue burst requests.
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_req_o && !prev_req) grant_log.push_back(mem_addr_o < 32'h100);
        prev_req = mem_req_o;
        if (if_valid_o) begin
            if_seen++;
            last_if_cyc = cyc;
            chk("if_valid_expected", 32'(if_q.size() != 0), 32'd1);
            if (if_q.size() != 0) begin
                e = if_q.pop_front();
                chk("if_rdata", if_rdata_o, e);
            end
            if (if_burst > 0) begin
                if_burst--;
                if_addr_i = if_addr_i + 32'd4;
                if_q.push_back(init_word(int'(if_addr_i[11:2])));
            end else begin
                if_req_i = 1'b0;
            end
        end
        if (dm_valid_o) begin
            dm_seen++;
            chk("dm_valid_expected", 32'(dm_q.size() != 0), 32'd1);
            if (dm_q.size() != 0) begin
                e = dm_q.pop_front();
                chk("dm_rdata", dm_rdata_o, e);
            end
            if (dm_burst > 0) begin
                dm_burst--;
                dm_addr_i = dm_addr_i + 32'd4;
                dm_we_i   = 1'b0;
                dm_q.push_back(init_word(int'(dm_addr_i[11:2])));
            end else begin
                dm_req_i = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int  n;
        bit  idle;
        n = 0;
        idle = 1'b0;
        while (n < budget && !idle) begin
            idle = !(if_req_i || dm_req_i || mem_req_o || if_q.size() != 0 || dm_q.size() != 0);
            if (!idle) begin
                step();
                n++;
            end
        end
        idle = !(if_req_i || dm_req_i || mem_req_o || if_q.size() != 0 || dm_q.size() != 0);
        chk(tag, 32'(idle), 32'd1);
    endtask

    task automatic issue_fetch(input logic [31:0] a);
        if_addr_i = a;
        if_req_i  = 1'b1;
        if_q.push_back(init_word(int'(a[11:2])));
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [31:0] exp);
        dm_addr_i = a;
        dm_we_i   = 1'b0;
        dm_be_i   = 4'hF;
        dm_req_i  = 1'b1;
        dm_q.push_back(exp);
    endtask

    initial begin
        int c0, s0;
        rst = 1'b1;
        if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = 32'h0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = 4'h0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
        repeat (3) step();
        chk("rst_mem_req",  32'(mem_req_o),  32'd0);
        chk("rst_mem_we",   32'(mem_we_o),   32'd0);
        chk("rst_mem_be",   32'(mem_be_o),   32'd0);
        chk("rst_mem_addr", mem_addr_o,      32'd0);
        chk("rst_if_valid", 32'(if_valid_o), 32'd0);
        chk("rst_dm_valid", 32'(dm_valid_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o,      32'd0);
        chk("rst_dm_rdata", dm_rdata_o,      32'd0);
        rst = 1'b0;
        step();

        // Fetch only, zero memory delay.
        mem_delay = 0;
        c0 = cyc;
        issue_fetch(32'h0000_0010);
        step();
        chk("t1_mem_req",  32'(mem_req_o),     32'd1);
        chk("t1_mem_addr", mem_addr_o,         32'h0000_0010);
        chk("t1_mem_we",   32'(mem_we_o),      32'd0);
        chk("t1_mem_be",   32'(mem_be_o),      32'h0000_000F);
        chk("t1_stall",    32'(stall_fetch_o), 32'd1);
        wait_idle("t1_idle", 50);
        chk("t1_latency",  32'(last_if_cyc - c0), 32'd2);

        // Simultaneous fetch and load: data wins, fetch follows.
        mem_delay = 2;
        grant_log.delete();
        issue_fetch(32'h0000_0020);
        issue_load(32'h0000_0100, init_word(64));
        wait_idle("t2_idle", 100);
        chk("t2_grant_cnt",   32'(grant_log.size()), 32'd2);
        chk("t2_grant_order", pack_grants(),         32'h0000_0002);

        // Streak limit: four data grants, one fetch, then again.
        mem_delay = 1;
        grant_log.delete();
        issue_fetch(32'h0000_0030);
        if_burst = 1;
        issue_load(32'h0000_0100, init_word(64));
        dm_burst = 7;
        wait_idle("t3_idle", 300);
        chk("t3_grant_cnt",   32'(grant_log.size()), 32'd10);
        chk("t3_grant_order", pack_grants(),         32'h0000_0210);

        // Partial store then readback.
        dm_addr_i = 32'h0000_0200; dm_we_i = 1'b1; dm_be_i = 4'b0011;
        dm_wdata_i = 32'hDEAD_BEEF; dm_req_i = 1'b1;
        dm_q.push_back(32'h0000_0000);
        step();
        chk("t4_mem_we",    32'(mem_we_o),    32'd1);
        chk("t4_mem_be",    32'(mem_be_o),    32'h0000_0003);
        chk("t4_mem_wdata", mem_wdata_o,      32'hDEAD_BEEF);
        chk("t4_mem_addr",  mem_addr_o,       32'h0000_0200);
        chk("t4_stall_mem", 32'(stall_mem_o), 32'd1);
        wait_idle("t4_store_idle", 50);
        issue_load(32'h0000_0200, merge_be(init_word(128), 32'hDEAD_BEEF, 4'b0011));
        wait_idle("t4_load_idle", 50);

        // Flush during BUSY_IF drops the old fetch; the redirected one completes.
        mem_delay = 3;
        grant_log.delete();
        s0 = if_seen;
        if_addr_i = 32'h0000_0040;
        if_req_i  = 1'b1;
        step();
        if_flush_i = 1'b1;
        issue_fetch(32'h0000_0044);
        step();
        if_flush_i = 1'b0;
        wait_idle("t5_idle", 100);
        chk("t5_if_valids", 32'(if_seen - s0),    32'd1);
        chk("t5_grants",    pack_grants(),        32'h0000_0003);
        chk("t5_grant_cnt", 32'(grant_log.size()), 32'd2);

        // Reset while a load is outstanding.
        s0 = dm_seen;
        dm_addr_i = 32'h0000_0104; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_req_i = 1'b1;
        step();
        chk("t6_grant", 32'(mem_req_o), 32'd1);
        step();
        rst = 1'b1;
        dm_req_i = 1'b0;
        step();
        chk("t6_rst_mem_req",  32'(mem_req_o),  32'd0);
        chk("t6_rst_dm_valid", 32'(dm_valid_o), 32'd0);
        rst = 1'b0;
        step();
        chk("t6_post_dm_valid", 32'(dm_valid_o), 32'd0);
        issue_load(32'h0000_0108, init_word(66));
        step();
        chk("t6_fresh_req",  32'(mem_req_o), 32'd1);
        chk("t6_fresh_addr", mem_addr_o,     32'h0000_0108);
        wait_idle("t6_idle", 50);
        chk("t6_dm_valids", 32'(dm_seen - s0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
